cordic_pre: RTL



---
 rtl/cordic_pkg.sv | 17 +
 rtl/cordic_dly_line.sv | 34 +++
 rtl/cordic_pre.sv | 118 +++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: default geometry, info-word bit positions and type.
// Used by cordic_pre, the iteration core and cordic_post.
package cordic_pkg;

  localparam int unsigned DW_DEF       = 16;  // gradient component width
  localparam int unsigned DW_DOT_DEF   = 4;   // fractional extension bits
  localparam int unsigned T_IR_NUM_DEF = 15;  // iteration-core latency

  localparam int unsigned INFO_W    = 3;
  localparam int unsigned INFO_XNEG = 2;
  localparam int unsigned INFO_YNEG = 1;
  localparam int unsigned INFO_SWAP = 0;

  // {x_neg, y_neg, swap} describing how the source vector was folded
  typedef logic [INFO_W-1:0] info_t;

endpackage

// File: rtl/cordic_dly_line.sv
// Fixed-depth shift register with no enable, clocked every cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   din_i    : WIDTH-bit data in
//   dout_o   : din_i delayed DEPTH cycles (DEPTH >= 1)
module cordic_dly_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  // Shift chain; reset flushes every tap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[0] <= din_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/cordic_pre.sv
// CORDIC pre-processing: folds a signed (gx, gy) vector into the 0..45 degree
// octant, extends it with DW_DOT fractional bits and emits the fold info word,
// delayed so it lines up with the data entering cordic_post.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   din_vsync/din_hsync  : frame valid / data valid in
//   din_x, din_y         : signed gx, gy (DW bits)
//   dout_vsync/dout_hsync: syncs delayed 2 cycles
//   dout_x, dout_y       : folded major/minor magnitudes, DW+DW_DOT bits, 2 cycles
//   dout_info            : {x_neg, y_neg, swap}, 2+T_IR_NUM cycles
module cordic_pre
  import cordic_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned DW_DOT   = DW_DOT_DEF,
  parameter int unsigned T_IR_NUM = T_IR_NUM_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_vsync,
  input  logic                 din_hsync,
  input  logic [DW-1:0]        din_x,
  input  logic [DW-1:0]        din_y,
  output logic                 dout_vsync,
  output logic                 dout_hsync,
  output logic [DW+DW_DOT-1:0] dout_x,
  output logic [DW+DW_DOT-1:0] dout_y,
  output logic [INFO_W-1:0]    dout_info
);

  localparam int unsigned OW = DW + DW_DOT;

  // Stage 1: signs and magnitudes
  logic          xneg_d, xneg_q;
  logic          yneg_d, yneg_q;
  logic [DW-1:0] ax_d, ax_q;
  logic [DW-1:0] ay_d, ay_q;
  logic          hs1_q, vs1_q;

  // Stage 2: octant fold
  logic          swap_d;
  logic [OW-1:0] x2_d, x2_q;
  logic [OW-1:0] y2_d, y2_q;
  info_t         info_d, info_q;
  logic          hs2_q, vs2_q;

  // Non-valid slots are forced to zero so they carry no info downstream.
  // The negation wraps, so the most negative input becomes 2^(DW-1) unsigned.
  always_comb begin
    xneg_d = 1'b0;
    yneg_d = 1'b0;
    ax_d   = '0;
    ay_d   = '0;
    if (din_hsync) begin
      xneg_d = din_x[DW-1];
      yneg_d = din_y[DW-1];
      ax_d   = xneg_d ? (~din_x + DW'(1)) : din_x;
      ay_d   = yneg_d ? (~din_y + DW'(1)) : din_y;
    end
  end

  // Larger magnitude goes to x; ties keep the original order
  always_comb begin
    swap_d = (ay_q > ax_q);
    x2_d   = OW'(swap_d ? ay_q : ax_q) << DW_DOT;
    y2_d   = OW'(swap_d ? ax_q : ay_q) << DW_DOT;
    info_d            = '0;
    info_d[INFO_XNEG] = xneg_q;
    info_d[INFO_YNEG] = yneg_q;
    info_d[INFO_SWAP] = swap_d;
  end

  // Pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xneg_q <= 1'b0;
      yneg_q <= 1'b0;
      ax_q   <= '0;
      ay_q   <= '0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      x2_q   <= '0;
      y2_q   <= '0;
      info_q <= '0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
    end else begin
      xneg_q <= xneg_d;
      yneg_q <= yneg_d;
      ax_q   <= ax_d;
      ay_q   <= ay_d;
      hs1_q  <= din_hsync;
      vs1_q  <= din_vsync;
      x2_q   <= x2_d;
      y2_q   <= y2_d;
      info_q <= info_d;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  assign dout_x     = x2_q;
  assign dout_y     = y2_q;
  assign dout_hsync = hs2_q;
  assign dout_vsync = vs2_q;

  // Info rides alongside the iteration core so it meets cordic_post's input
  cordic_dly_line #(
    .WIDTH (INFO_W),
    .DEPTH (T_IR_NUM)
  ) u_info_dly (
    .clk    (clk),
    .rst    (rst),
    .din_i  (info_q),
    .dout_o (dout_info)
  );

endmodule
